// File: rtl/cycle_sequencer_4004_if.sv
// rtl/cycle_sequencer_4004_if.sv - bus and control signal bundle for the 4004 cycle sequencer
interface cycle_sequencer_4004_if;
   logic [3:0]  data_in;
   logic        stall;
   logic        pc_load;
   logic [11:0] pc_target;
   logic        sync;
   logic [2:0]  phase;
   logic        addr_oe;
   logic [3:0]  addr_out;
   logic        opr_we;
   logic        opa_we;
   logic        w2_hi_we;
   logic        w2_lo_we;
   logic        exec_en;
   logic [3:0]  opr;
   logic [3:0]  opa;
   logic        second_word;
   logic [11:0] pc;

   // sequencer side
   modport slave (
      input  data_in, stall, pc_load, pc_target,
      output sync, phase, addr_oe, addr_out, opr_we, opa_we, w2_hi_we, w2_lo_we,
             exec_en, opr, opa, second_word, pc
   );

   // pins / control unit side
   modport master (
      output data_in, stall, pc_load, pc_target,
      input  sync, phase, addr_oe, addr_out, opr_we, opa_we, w2_hi_we, w2_lo_we,
             exec_en, opr, opa, second_word, pc
   );
endinterface

// File: rtl/cycle_sequencer_4004.sv
// rtl/cycle_sequencer_4004.sv - eight-phase 4004 instruction-cycle sequencer; optional stall via SEQ_STALL_EN
module cycle_sequencer_4004 #(
   parameter logic [11:0] PC_RESET = 12'h000
) (
   input  logic                   clk_2,
   input  logic                   reset,
   cycle_sequencer_4004_if.slave  bus
);

   typedef enum logic [2:0] {
      A1 = 3'd0, A2 = 3'd1, A3 = 3'd2, M1 = 3'd3,
      M2 = 3'd4, X1 = 3'd5, X2 = 3'd6, X3 = 3'd7
   } phase_t;

   phase_t      ph;
   logic [11:0] pc_q;
   logic [3:0]  opr_q;
   logic [3:0]  opa_q;
   logic        sw_q;        // current cycle fetches the second word
   logic        two_pend_q;  // first word of a two-word instruction seen this cycle
   logic        started_q;   // low only in the X3 that reset parks us in
   logic        adv;
   logic        is_two;

`ifdef SEQ_STALL_EN
   assign adv = ~bus.stall;
`else
   logic unused_stall;
   assign unused_stall = bus.stall;
   assign adv = 1'b1;
`endif

   // Classify OPR (captured at end of M1) with OPA bit 0 on the bus during M2
   always_comb begin
      is_two = 1'b0;
      case (opr_q)
         4'h1, 4'h4, 4'h5, 4'h7: is_two = 1'b1;
         4'h2:                   is_two = ~bus.data_in[0];
         default:                is_two = 1'b0;
      endcase
   end

   // Phase sequencing, PC update, operand capture and two-word tracking
   always_ff @(posedge clk_2 or negedge reset) begin
      if (!reset) begin
         ph         <= X3;
         pc_q       <= PC_RESET;
         opr_q      <= 4'h0;
         opa_q      <= 4'h0;
         sw_q       <= 1'b0;
         two_pend_q <= 1'b0;
         started_q  <= 1'b0;
      end else if (adv) begin
         ph <= phase_t'(ph + 3'd1);
         case (ph)
            A3: pc_q <= pc_q + 12'd1;
            M1: if (!sw_q) opr_q <= bus.data_in;
            M2: begin
               if (!sw_q) begin
                  opa_q      <= bus.data_in;
                  two_pend_q <= is_two;
               end
            end
            X3: begin
               started_q  <= 1'b1;
               if (bus.pc_load) pc_q <= bus.pc_target;
               // a second-word cycle always ends the instruction
               sw_q       <= sw_q ? 1'b0 : two_pend_q;
               two_pend_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Address nibble mux for A1..A3, bus released elsewhere
   always_comb begin
      bus.addr_out = 4'h0;
      case (ph)
         A1:      bus.addr_out = pc_q[3:0];
         A2:      bus.addr_out = pc_q[7:4];
         A3:      bus.addr_out = pc_q[11:8];
         default: bus.addr_out = 4'h0;
      endcase
   end

   assign bus.sync        = (ph == X3);
   assign bus.phase       = ph;
   assign bus.addr_oe     = (ph == A1) || (ph == A2) || (ph == A3);
   assign bus.opr_we      = adv && (ph == M1) && !sw_q;
   assign bus.opa_we      = adv && (ph == M2) && !sw_q;
   assign bus.w2_hi_we    = adv && (ph == M1) &&  sw_q;
   assign bus.w2_lo_we    = adv && (ph == M2) &&  sw_q;
   assign bus.exec_en     = started_q && !two_pend_q && ((ph == X1) || (ph == X2) || (ph == X3));
   assign bus.opr         = opr_q;
   assign bus.opa         = opa_q;
   assign bus.second_word = sw_q;
   assign bus.pc          = pc_q;

endmodule

// File: tb/tb_cycle_sequencer_4004.sv
// tb/tb_cycle_sequencer_4004.sv - directed self-checking bench for cycle_sequencer_4004
module tb_cycle_sequencer_4004;

   logic clk_2 = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   cycle_sequencer_4004_if bus ();

   cycle_sequencer_4004 #(.PC_RESET(12'h000)) dut (
      .clk_2 (clk_2),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk_2 = ~clk_2;

   task automatic step();
      @(posedge clk_2);
      @(negedge clk_2);
   endtask

   task automatic advance_to(input logic [2:0] p);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (bus.phase !== p && n < 16);
      checks++;
      if (bus.phase !== p) begin errors++; $display("FAIL advance_to got=%0d exp=%0d", bus.phase, p); end
   endtask

   task automatic test_reset();
      reset = 1'b0; bus.data_in = 4'h0; bus.stall = 1'b0; bus.pc_load = 1'b0; bus.pc_target = 12'h000;
      step(); step();
      checks++; if (bus.phase !== 3'd7) begin errors++; $display("FAIL rst_phase got=%0d exp=7", bus.phase); end
      checks++; if (bus.sync !== 1'b1) begin errors++; $display("FAIL rst_sync got=%b exp=1", bus.sync); end
      checks++; if (bus.pc !== 12'h000) begin errors++; $display("FAIL rst_pc got=%h exp=000", bus.pc); end
      checks++; if (bus.addr_oe !== 1'b0) begin errors++; $display("FAIL rst_addr_oe got=%b exp=0", bus.addr_oe); end
      checks++; if (bus.exec_en !== 1'b0) begin errors++; $display("FAIL rst_exec_en got=%b exp=0", bus.exec_en); end
      checks++; if ({bus.opr, bus.opa, bus.second_word} !== 9'h0) begin errors++; $display("FAIL rst_regs got=%h exp=0", {bus.opr, bus.opa, bus.second_word}); end
      reset = 1'b1;
      checks++; if (bus.exec_en !== 1'b0) begin errors++; $display("FAIL rel_exec_en got=%b exp=0", bus.exec_en); end
      step();
      checks++; if (bus.phase !== 3'd0) begin errors++; $display("FAIL first_a1 got=%0d exp=0", bus.phase); end
      checks++; if (bus.addr_oe !== 1'b1 || bus.addr_out !== 4'h0) begin errors++; $display("FAIL first_addr got=%b/%h exp=1/0", bus.addr_oe, bus.addr_out); end
   endtask

   task automatic test_seq_fetch();
      advance_to(3'd3);
      checks++; if (bus.pc !== 12'h001) begin errors++; $display("FAIL seq_pc_inc got=%h exp=001", bus.pc); end
      checks++; if (bus.opr_we !== 1'b1 || bus.opa_we !== 1'b0) begin errors++; $display("FAIL seq_opr_we got=%b%b exp=10", bus.opr_we, bus.opa_we); end
      bus.data_in = 4'hD;
      advance_to(3'd4);
      checks++; if (bus.opr !== 4'hD) begin errors++; $display("FAIL seq_opr got=%h exp=d", bus.opr); end
      checks++; if (bus.opa_we !== 1'b1) begin errors++; $display("FAIL seq_opa_we got=%b exp=1", bus.opa_we); end
      bus.data_in = 4'h5;
      advance_to(3'd5);
      checks++; if (bus.opa !== 4'h5) begin errors++; $display("FAIL seq_opa got=%h exp=5", bus.opa); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (bus.exec_en !== 1'b1) begin errors++; $display("FAIL seq_exec_x%0d got=%b exp=1", i + 1, bus.exec_en); end
         if (i < 2) step();
      end
      checks++; if (bus.sync !== 1'b1) begin errors++; $display("FAIL seq_sync got=%b exp=1", bus.sync); end
      step();
      checks++; if (bus.addr_out !== 4'h1) begin errors++; $display("FAIL seq_a1 got=%h exp=1", bus.addr_out); end
      step();
      checks++; if (bus.addr_out !== 4'h0) begin errors++; $display("FAIL seq_a2 got=%h exp=0", bus.addr_out); end
      step();
      checks++; if (bus.addr_out !== 4'h0) begin errors++; $display("FAIL seq_a3 got=%h exp=0", bus.addr_out); end
   endtask

   task automatic test_two_word_jun();
      advance_to(3'd3);
      bus.data_in = 4'h4;
      advance_to(3'd4);
      bus.data_in = 4'h0;
      advance_to(3'd5);
      for (int i = 0; i < 3; i++) begin
         checks++; if (bus.exec_en !== 1'b0) begin errors++; $display("FAIL jun_w1_exec_x%0d got=%b exp=0", i + 1, bus.exec_en); end
         if (i < 2) step();
      end
      step();
      checks++; if (bus.second_word !== 1'b1) begin errors++; $display("FAIL jun_sw_set got=%b exp=1", bus.second_word); end
      checks++; if (bus.addr_out !== 4'h2) begin errors++; $display("FAIL jun_w2_addr got=%h exp=2", bus.addr_out); end
      advance_to(3'd3);
      checks++; if (bus.w2_hi_we !== 1'b1 || bus.opr_we !== 1'b0) begin errors++; $display("FAIL jun_w2_hi got=%b%b exp=10", bus.w2_hi_we, bus.opr_we); end
      bus.data_in = 4'hA;
      advance_to(3'd4);
      checks++; if (bus.w2_lo_we !== 1'b1 || bus.opa_we !== 1'b0) begin errors++; $display("FAIL jun_w2_lo got=%b%b exp=10", bus.w2_lo_we, bus.opa_we); end
      checks++; if (bus.opr !== 4'h4) begin errors++; $display("FAIL jun_opr_held got=%h exp=4", bus.opr); end
      bus.data_in = 4'hB;
      advance_to(3'd5);
      checks++; if (bus.exec_en !== 1'b1 || bus.opa !== 4'h0) begin errors++; $display("FAIL jun_w2_exec got=%b/%h exp=1/0", bus.exec_en, bus.opa); end
      advance_to(3'd0);
      checks++; if (bus.second_word !== 1'b0) begin errors++; $display("FAIL jun_sw_clr got=%b exp=0", bus.second_word); end
      checks++; if (bus.addr_out !== 4'h3) begin errors++; $display("FAIL jun_next_addr got=%h exp=3", bus.addr_out); end
   endtask

   task automatic test_fim_src();
      advance_to(3'd3);
      bus.data_in = 4'h2;
      advance_to(3'd4);
      bus.data_in = 4'h0;
      advance_to(3'd0);
      checks++; if (bus.second_word !== 1'b1) begin errors++; $display("FAIL fim_sw got=%b exp=1", bus.second_word); end
      advance_to(3'd3);
      bus.data_in = 4'h0;
      advance_to(3'd0);
      checks++; if (bus.second_word !== 1'b0) begin errors++; $display("FAIL fim_sw_clr got=%b exp=0", bus.second_word); end
      advance_to(3'd3);
      bus.data_in = 4'h2;
      advance_to(3'd4);
      bus.data_in = 4'h1;
      advance_to(3'd5);
      checks++; if (bus.exec_en !== 1'b1) begin errors++; $display("FAIL src_exec got=%b exp=1", bus.exec_en); end
      advance_to(3'd0);
      checks++; if (bus.second_word !== 1'b0) begin errors++; $display("FAIL src_sw got=%b exp=0", bus.second_word); end
      checks++; if (bus.pc !== 12'h006) begin errors++; $display("FAIL src_pc got=%h exp=006", bus.pc); end
   endtask

   task automatic test_jump_wrap();
      bus.data_in = 4'h0;
      advance_to(3'd7);
      bus.pc_load = 1'b1; bus.pc_target = 12'hFFF;
      step();
      bus.pc_load = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++; if (bus.addr_out !== 4'hF) begin errors++; $display("FAIL jmp_a%0d got=%h exp=f", i + 1, bus.addr_out); end
         step();
      end
      checks++; if (bus.pc !== 12'h000) begin errors++; $display("FAIL jmp_wrap got=%h exp=000", bus.pc); end
      checks++; if (bus.addr_oe !== 1'b0 || bus.addr_out !== 4'h0) begin errors++; $display("FAIL jmp_m1_addr got=%b/%h exp=0/0", bus.addr_oe, bus.addr_out); end
      bus.pc_load = 1'b1; bus.pc_target = 12'h123;
      step();
      bus.pc_load = 1'b0;
      checks++; if (bus.pc !== 12'h000) begin errors++; $display("FAIL jmp_ignored got=%h exp=000", bus.pc); end
   endtask

   task automatic test_stall();
      advance_to(3'd3);
      bus.data_in = 4'h9;
      bus.stall = 1'b1;
`ifdef SEQ_STALL_EN
      checks++; if (bus.opr_we !== 1'b0) begin errors++; $display("FAIL stall_gate got=%b exp=0", bus.opr_we); end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (bus.phase !== 3'd3 || bus.opr_we !== 1'b0 || bus.opr !== 4'h0) begin errors++; $display("FAIL stall_hold%0d got=%0d/%b/%h exp=3/0/0", i, bus.phase, bus.opr_we, bus.opr); end
      end
      bus.stall = 1'b0;
      checks++; if (bus.opr_we !== 1'b1) begin errors++; $display("FAIL stall_release got=%b exp=1", bus.opr_we); end
      step();
`else
      checks++; if (bus.opr_we !== 1'b1) begin errors++; $display("FAIL stall_ignored got=%b exp=1", bus.opr_we); end
      step();
      bus.stall = 1'b0;
`endif
      checks++; if (bus.phase !== 3'd4 || bus.opr !== 4'h9) begin errors++; $display("FAIL stall_capture got=%0d/%h exp=4/9", bus.phase, bus.opr); end
      checks++; if (bus.pc !== 12'h001) begin errors++; $display("FAIL stall_pc got=%h exp=001", bus.pc); end
      bus.data_in = 4'h0;
      advance_to(3'd7);
      bus.stall = 1'b1; bus.pc_load = 1'b1; bus.pc_target = 12'h2A5;
`ifdef SEQ_STALL_EN
      step();
      checks++; if (bus.phase !== 3'd7 || bus.pc !== 12'h001) begin errors++; $display("FAIL stall_x3 got=%0d/%h exp=7/001", bus.phase, bus.pc); end
`endif
      bus.stall = 1'b0;
      step();
      bus.pc_load = 1'b0;
      checks++; if (bus.phase !== 3'd0 || bus.pc !== 12'h2A5) begin errors++; $display("FAIL stall_jump got=%0d/%h exp=0/2a5", bus.phase, bus.pc); end
   endtask

   task automatic test_reset_mid();
      advance_to(3'd3);
      bus.data_in = 4'h4;
      advance_to(3'd4);
      bus.data_in = 4'h0;
      advance_to(3'd5);
      bus.stall = 1'b1;
      reset = 1'b0;
      #1;
      checks++; if (bus.phase !== 3'd7 || bus.sync !== 1'b1) begin errors++; $display("FAIL mid_rst_phase got=%0d/%b exp=7/1", bus.phase, bus.sync); end
      checks++; if (bus.pc !== 12'h000 || bus.opr !== 4'h0) begin errors++; $display("FAIL mid_rst_regs got=%h/%h exp=000/0", bus.pc, bus.opr); end
      checks++; if (bus.exec_en !== 1'b0) begin errors++; $display("FAIL mid_rst_exec got=%b exp=0", bus.exec_en); end
      step();
      bus.stall = 1'b0;
      reset = 1'b1;
      step();
      checks++; if (bus.phase !== 3'd0 || bus.second_word !== 1'b0) begin errors++; $display("FAIL mid_rst_after got=%0d/%b exp=0/0", bus.phase, bus.second_word); end
      checks++; if (bus.addr_out !== 4'h0) begin errors++; $display("FAIL mid_rst_addr got=%h exp=0", bus.addr_out); end
   endtask

   initial begin
      test_reset();
      test_seq_fetch();
      test_two_word_jun();
      test_fim_src();
      test_jump_wrap();
      test_stall();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
